// File: rtl/booth_simd_scheduler.sv
// Round-robin scheduler sharing one SIMD Booth multiplier among NREQ units.
// Optional watchdog on the multiplier handshake: define MUL_TIMEOUT_EN.
module booth_simd_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
`ifdef MUL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  req_mode,
  input  logic [16*NREQ-1:0] req_m,
  input  logic [16*NREQ-1:0] req_q,
  output logic [NREQ-1:0]    gnt,
  output logic               mul_start,
  output logic [1:0]         mul_mode,
  output logic [15:0]        mul_m,
  output logic [15:0]        mul_q,
  input  logic [31:0]        mul_result,
  input  logic               mul_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] win;
  logic           any;
  logic [1:0]     win_mode;
  logic [15:0]    win_m;
  logic [15:0]    win_q;
  logic           win_bad;
  logic           tmo;

  assign win_mode  = req_mode[{win, 1'b0} +: 2];
  assign win_m     = req_m[{win, 4'h0} +: 16];
  assign win_q     = req_q[{win, 4'h0} +: 16];
  assign win_bad   = (win_mode == 2'b11);
  assign rsp_valid = (state == RESP);

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    idx = '0;
    win = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Watchdog: counts WAIT cycles of the current job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (state == WAIT) && !mul_done &&
               (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // Next-state logic of the job sequencer.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any) state_nx = ISSUE;
      ISSUE:   state_nx = rsp_err ? RESP : WAIT;
      WAIT:    if (mul_done || tmo) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register plus grant, operand latches and response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      mul_start  <= 1'b0;
      mul_mode   <= 2'b00;
      mul_m      <= '0;
      mul_q      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      gnt   <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt        <= NREQ'(1) << win;
            ptr        <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            rsp_id     <= win;
            rsp_err    <= win_bad;
            rsp_result <= '0;
            // reserved mode never reaches the multiplier
            if (!win_bad) begin
              mul_mode <= win_mode;
              mul_m    <= win_m;
              mul_q    <= win_q;
            end
          end
        end
        ISSUE: mul_start <= !rsp_err;
        WAIT: begin
          if (mul_done) begin
            mul_start  <= 1'b0;
            rsp_result <= mul_result;
          end else if (tmo) begin
            mul_start <= 1'b0;
            rsp_err   <= 1'b1;
          end
        end
        RESP: mul_start <= 1'b0;
        default: mul_start <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_simd_scheduler.sv
// Directed bench for booth_simd_scheduler with a fixed-latency multiplier
// model (done 8 cycles after start); timeout steps need MUL_TIMEOUT_EN.
module tb_booth_simd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  req_mode;
  logic [63:0] req_m;
  logic [63:0] req_q;
  logic [3:0]  gnt;
  logic        mul_start;
  logic [1:0]  mul_mode;
  logic [15:0] mul_m;
  logic [15:0] mul_q;
  logic [31:0] mul_result;
  logic        mul_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic prev = 1'b0;
  int   cyc = 0;
  logic done_en = 1'b1;
  logic late = 1'b0;

  booth_simd_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_mode   (req_mode),
    .req_m      (req_m),
    .req_q      (req_q),
    .gnt        (gnt),
    .mul_start  (mul_start),
    .mul_mode   (mul_mode),
    .mul_m      (mul_m),
    .mul_q      (mul_q),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] md,
                                        input logic [15:0] m,
                                        input logic [15:0] q);
    logic [31:0] r;
    r = '0;
    case (md)
      2'b00: r = {16'h0, m} * {16'h0, q};
      2'b01: begin
        r[31:16] = {8'h0, m[15:8]} * {8'h0, q[15:8]};
        r[15:0]  = {8'h0, m[7:0]} * {8'h0, q[7:0]};
      end
      2'b10: begin
        for (int i = 0; i < 4; i++)
          r[8*i +: 8] = {4'h0, m[4*i +: 4]} * {4'h0, q[4*i +: 4]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    prev <= mul_start;
    if (mul_start && !prev) cyc <= 1;
    else if (mul_start) cyc <= cyc + 1;
    else cyc <= 0;
  end

  assign mul_done   = (mul_start && done_en && cyc == 8) || late;
  assign mul_result = mul_done ? model(mul_mode, mul_m, mul_q) : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic job(input logic [3:0] exp_g, input logic [1:0] exp_id,
                     input logic [31:0] exp_res, input logic exp_err,
                     input int exp_starts, input int exp_lat,
                     input string tag);
    int n;
    int starts;
    int extra;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " gnt"}, 32'(gnt), 32'(exp_g));
    starts = 0;
    extra = 0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
      if (mul_start) starts++;
      if (gnt != 4'b0) extra++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " starts"}, 32'(starts), 32'(exp_starts));
    chk({tag, " extra_gnt"}, 32'(extra), 32'h0);
    chk({tag, " id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, " result"}, rsp_result, exp_res);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench hung");
  end

  initial begin
    int n;
    int bad;
    rst_n = 1'b0;
    req = '0;
    req_mode = '0;
    req_m = '0;
    req_q = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst mul_start", 32'(mul_start), 32'h0);
    chk("rst mul_mode", 32'(mul_mode), 32'h0);
    chk("rst mul_m", 32'(mul_m), 32'h0);
    chk("rst mul_q", 32'(mul_q), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_id", 32'(rsp_id), 32'h0);
    chk("rst rsp_result", rsp_result, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // round robin, all four requesting
    for (int i = 0; i < 4; i++) begin
      req_m[16*i +: 16] = 16'(i + 1);
      req_q[16*i +: 16] = 16'h0002;
    end
    req = 4'b1111;
    job(4'b0001, 2'd0, 32'd2, 1'b0, 9, 10, "rr0");
    job(4'b0010, 2'd1, 32'd4, 1'b0, 9, 10, "rr1");
    job(4'b0100, 2'd2, 32'd6, 1'b0, 9, 10, "rr2");
    job(4'b1000, 2'd3, 32'd8, 1'b0, 9, 10, "rr3");
    job(4'b0001, 2'd0, 32'd2, 1'b0, 9, 10, "rr4");
    req = '0;
    tick();

    // single full-width job
    req_m[15:0] = 16'h7536;
    req_q[15:0] = 16'h7536;
    req = 4'b0001;
    job(4'b0001, 2'd0, 32'h35AA6764, 1'b0, 9, 10, "single");
    req = '0;
    tick();

    // 2x8x8 lanes on requester 2
    req_mode[5:4] = 2'b01;
    req_m[47:32] = 16'h0302;
    req_q[47:32] = 16'h0405;
    req = 4'b0100;
    job(4'b0100, 2'd2, 32'h000C000A, 1'b0, 9, 10, "mode01");
    req = '0;
    chk("mode01 mul_mode", 32'(mul_mode), 32'h1);
    tick();

    // 4x4x4 lanes on requester 3
    req_mode[7:6] = 2'b10;
    req_m[63:48] = 16'h4321;
    req_q[63:48] = 16'h1234;
    req = 4'b1000;
    job(4'b1000, 2'd3, 32'h04060604, 1'b0, 9, 10, "mode10");
    req = '0;
    chk("mode10 mul_q", 32'(mul_q), 32'h1234);
    tick();

    // reserved mode on requester 1
    req_mode[3:2] = 2'b11;
    req = 4'b0010;
    job(4'b0010, 2'd1, 32'h0, 1'b1, 0, 1, "reserved");
    req = '0;
    chk("reserved mul_mode kept", 32'(mul_mode), 32'h2);
    tick();

    // backpressure holds the response
    req_m[15:0] = 16'h0005;
    req_q[15:0] = 16'h0007;
    rsp_ready = 1'b0;
    req = 4'b0001;
    job(4'b0001, 2'd0, 32'h23, 1'b0, 9, 10, "bp");
    req = '0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(rsp_valid && rsp_id == 2'd0 && rsp_result == 32'h23 && !rsp_err))
        bad++;
    end
    chk("bp stable", 32'(bad), 32'h0);
    rsp_ready = 1'b1;
    tick();
    chk("bp released", 32'(rsp_valid), 32'h0);

    // reset in the middle of WAIT
    req = 4'b0001;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    req = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid start", 32'(mul_start), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mid rst mul_start", 32'(mul_start), 32'h0);
    chk("mid rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid rst mul_m", 32'(mul_m), 32'h0);
    chk("mid rst rsp_result", rsp_result, 32'h0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || mul_start || gnt != 4'b0) bad++;
    end
    chk("mid rst quiet", 32'(bad), 32'h0);

    // stray done while idle
    late = 1'b1;
    tick();
    late = 1'b0;
    tick();
    chk("stray done", 32'({rsp_valid, mul_start}), 32'h0);

`ifdef MUL_TIMEOUT_EN
    done_en = 1'b0;
    req_m[15:0] = 16'h0003;
    req = 4'b0001;
    job(4'b0001, 2'd0, 32'h0, 1'b1, 64, 65, "timeout");
    req = '0;
    chk("timeout start low", 32'(mul_start), 32'h0);
    tick();
    late = 1'b1;
    tick();
    late = 1'b0;
    tick();
    chk("timeout late done", 32'({rsp_valid, mul_start}), 32'h0);
    done_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_simd_scheduler.md
Name: booth_simd_scheduler

Overview:
- Shares one SIMD Booth multiplier (booth_controller: mode/start/M/Q in, 32-bit result/done out) among NREQ requesters.
- Round-robin arbitration; latches the winner's operands and mode, then sequences start/done on the multiplier.
- Returns the result tagged with the requester ID over a valid/ready response port.
- Sits between the requesting datapath units and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 64, watchdog limit in cycles (used only with MUL_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request; held high until granted.
- req_mode  in  2*NREQ  packed mode per requester: 00=1x16x16, 01=2x8x8, 10=4x4x4, 11=reserved.
- req_m  in  16*NREQ  packed multiplicand per requester.
- req_q  in  16*NREQ  packed multiplier per requester.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- mul_start  out  1  start to the multiplier.
- mul_mode  out  2  mode to the multiplier.
- mul_m  out  16  M to the multiplier.
- mul_q  out  16  Q to the multiplier.
- mul_result  in  32  multiplier result.
- mul_done  in  1  multiplier completion.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  IDW  index of the serviced requester.
- rsp_result  out  32  product, lanes packed as the multiplier produces them.
- rsp_err  out  1  1 = reserved mode, or timeout (feature enabled).

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; all outputs 0; RR pointer=0 (requester 0 has highest priority first). A reset mid-job abandons the job: no response is produced and mul_start drops on the next edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit scanning from ptr, ptr+1, ... with wrap mod NREQ.
  - Pulse gnt[w] for one cycle; latch mode/M/Q/id; set ptr = w+1 mod NREQ.
  - Valid mode -> ISSUE. Mode 11 -> RESP with rsp_err=1, rsp_result=0; multiplier not touched.
- ISSUE: one cycle. mul_start=1; mul_mode/mul_m/mul_q driven from the latches -> WAIT.
- WAIT:
  - mul_start held 1; operands held stable.
  - On mul_done=1: capture mul_result, drop mul_start -> RESP.
  - A mul_done seen in ISSUE is ignored.
- RESP:
  - rsp_valid=1 with id/result/err stable until rsp_ready=1; the handshake completes on that edge -> IDLE.
  - mul_start=0 throughout, guaranteeing at least 2 low cycles between jobs.
- Latency with an ideal multiplier (done N cycles after start) and rsp_ready tied high: gnt at cycle 0, rsp_valid at N+2, next gnt at N+4.
- New requests arriving in ISSUE/WAIT/RESP wait; gnt is never asserted outside IDLE.
- Requests are sampled only in IDLE. A requester dropping req before grant loses nothing.
- Simultaneous requests: RR order only; no starvation. A requester waits at most NREQ-1 jobs.
- mul_m/mul_q/mul_mode keep their last latched values when idle (no X).

Optional Feature:
- MUL_TIMEOUT_EN defined: a counter starts at ISSUE.
  - If mul_done has not arrived after TIMEOUT cycles in WAIT: drop mul_start -> RESP with rsp_err=1, rsp_result=0.
  - A late mul_done arriving in RESP/IDLE is ignored.
- Undefined: no counter; WAIT waits indefinitely; rsp_err is set only for reserved mode.

Test Plan:
- Single job: req[0]=1, mode=00, M=Q=16'h7536; model done 8 cycles after start -> gnt[0] pulse, mul_start high 9 cycles, rsp_valid with rsp_id=0, rsp_result=32'h35AA6764, rsp_err=0.
- Round robin: req=4'b1111 held, each requester M=id+1, Q=16'h0002, mode=00 -> service order 0,1,2,3,0; results 2,4,6,8,2; exactly one gnt bit per job.
- Modes 01/10: requester 2, mode=01, M=16'h0302, Q=16'h0405 -> mul_mode=01 driven; rsp_result equals the model's packed 2x8x8 result {16'h000C,16'h000A}.
- Reserved mode: req[1]=1, mode=11 -> gnt[1] pulse, no mul_start, rsp_valid next cycle with rsp_err=1, rsp_result=0.
- Backpressure + reset: rsp_ready=0 for 10 cycles -> rsp_* stable; deassert rst_n during WAIT -> all outputs 0 next edge, no response emitted.
- MUL_TIMEOUT_EN, TIMEOUT=64, model never asserts done -> rsp_err=1 after 64 WAIT cycles; mul_start low; a later done is ignored.
